// File: rtl/out_drain_ctrlr.sv
// out_drain_ctrlr: drains finished output rows from per-core row memories into
// the global output memory. Cores with a finished row are served round-robin;
// each row is streamed one element per cycle and written in HWC order at
// base = tag * (IMG_W*OC). The core's buffer is released only after its last
// element has been written.
//
// state  | meaning
// IDLE   | waiting for start; done high
// ARB    | searching for a core with a finished row, starting at rr_ptr
// DRAIN  | reading the granted core's row memory, one address per cycle
// ACK    | last write lands; drained pulse to the granted core
// DONE   | all rows of the layer written; done high for one cycle

module out_drain_ctrlr #(
  parameter int NUM_CORE     = 4,
  parameter int OUTPUT_BW    = 8,
  parameter int OUT_PER_CORE = 14,
  parameter int ADDR_OUT     = 20,
  localparam int SEL_W       = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        done,
  input  logic [5:0]                  IMG_H,
  input  logic [5:0]                  IMG_W,
  input  logic [7:0]                  OC,
  input  logic [NUM_CORE-1:0]         which_core_result_valid,
  input  logic [NUM_CORE*6-1:0]       core_row_tag,
  output logic [NUM_CORE-1:0]         which_core_drained,
  output logic [SEL_W-1:0]            out_row_mem_sel,
  output logic                        out_row_mem_en,
  output logic [OUT_PER_CORE-1:0]     out_row_mem_addr,
  input  logic signed [OUTPUT_BW-1:0] out_row_mem_data,
  output logic signed [OUTPUT_BW-1:0] out_mem_data,
  output logic [ADDR_OUT-1:0]         out_mem_addr,
  output logic                        out_mem_we
);

  localparam int BASE_W = OUT_PER_CORE + 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_DRAIN,
    ST_ACK,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [5:0]              img_h_q;
  logic [5:0]              img_w_q;
  logic [7:0]              oc_q;
  logic [5:0]              rows_done;
  logic [SEL_W-1:0]        grant;
  logic [SEL_W-1:0]        rr_ptr;
  logic [ADDR_OUT-1:0]     base;
  logic                    en_d;
  logic [OUT_PER_CORE-1:0] rd_cnt_d;

  logic [OUT_PER_CORE-1:0] tile_len;
  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic [SEL_W:0]          probe;
  logic [5:0]              hit_tag;
  logic [BASE_W-1:0]       base_full;

  // Row length comes from the values latched at start, never the live inputs.
  assign tile_len  = OUT_PER_CORE'(img_w_q) * OUT_PER_CORE'(oc_q);
  assign hit_tag   = core_row_tag[int'(hit_idx)*6 +: 6];
  assign base_full = BASE_W'(hit_tag) * BASE_W'(tile_len);

  // First valid core at or after rr_ptr, wrapping around.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    probe   = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      probe = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (probe >= (SEL_W+1)'(NUM_CORE)) probe = probe - (SEL_W+1)'(NUM_CORE);
      if (!hit && which_core_result_valid[probe[SEL_W-1:0]]) begin
        hit     = 1'b1;
        hit_idx = probe[SEL_W-1:0];
      end
    end
  end

  assign out_row_mem_sel = grant;

  // Row memory data arrives one cycle after the read, so the write side uses
  // the delayed enable/address paired with the live read data.
  assign out_mem_we   = en_d;
  assign out_mem_addr = en_d ? (base + ADDR_OUT'(rd_cnt_d)) : '0;
  assign out_mem_data = en_d ? out_row_mem_data : '0;

  // Sequencer with registered outputs, plus the one-cycle write-path delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      img_h_q            <= '0;
      img_w_q            <= '0;
      oc_q               <= '0;
      rows_done          <= '0;
      grant              <= '0;
      rr_ptr             <= '0;
      base               <= '0;
      en_d               <= 1'b0;
      rd_cnt_d           <= '0;
      done               <= 1'b1;
      which_core_drained <= '0;
      out_row_mem_en     <= 1'b0;
      out_row_mem_addr   <= '0;
    end else begin
      en_d     <= out_row_mem_en;
      rd_cnt_d <= out_row_mem_addr;
      case (state)
        ST_IDLE: begin
          if (start) begin
            img_h_q   <= IMG_H;
            img_w_q   <= IMG_W;
            oc_q      <= OC;
            rows_done <= '0;
            rr_ptr    <= '0;
            if (IMG_H == 6'd0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ARB;
              done  <= 1'b0;
            end
          end
        end
        ST_ARB: begin
          if (hit) begin
            grant            <= hit_idx;
            base             <= ADDR_OUT'(base_full);
            out_row_mem_addr <= '0;
            if (tile_len == '0) begin
              // Empty row: nothing to read, release the buffer right away.
              which_core_drained <= NUM_CORE'(1) << hit_idx;
              state              <= ST_ACK;
            end else begin
              out_row_mem_en <= 1'b1;
              state          <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_row_mem_addr == tile_len - OUT_PER_CORE'(1)) begin
            out_row_mem_en     <= 1'b0;
            out_row_mem_addr   <= '0;
            which_core_drained <= NUM_CORE'(1) << grant;
            state              <= ST_ACK;
          end else begin
            out_row_mem_addr <= out_row_mem_addr + OUT_PER_CORE'(1);
          end
        end
        ST_ACK: begin
          which_core_drained <= '0;
          rows_done          <= rows_done + 6'd1;
          rr_ptr             <= (int'(grant) == NUM_CORE-1) ? '0 : grant + SEL_W'(1);
          if (7'(rows_done) + 7'd1 == 7'(img_h_q)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_ARB;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_drain_ctrlr.sv
// Testbench for out_drain_ctrlr: core-side row buffers and valid/tag handshake
// are modelled here; expected writes and drain order come from a row-level
// round-robin model over per-core row queues.

module tb_out_drain_ctrlr;
  localparam int NC   = 4;
  localparam int MEMD = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              done;
  logic [5:0]        img_h;
  logic [5:0]        img_w;
  logic [7:0]        oc;
  logic [NC-1:0]     valid;
  logic [NC*6-1:0]   tags;
  logic [NC-1:0]     drained;
  logic [1:0]        sel;
  logic              en;
  logic [13:0]       raddr;
  logic signed [7:0] rdata = '0;
  logic signed [7:0] wdata;
  logic [19:0]       waddr;
  logic              we;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [NC][MEMD];
  int         q_tag  [NC][$];
  int         q_seed [NC][$];
  bit         pend   [NC];

  always #5 clk = ~clk;

  // Row memory: 1-cycle read latency.
  always @(posedge clk) if (en) rdata <= mem[sel][raddr[9:0]];

  out_drain_ctrlr dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .IMG_H(img_h), .IMG_W(img_w), .OC(oc),
    .which_core_result_valid(valid), .core_row_tag(tags),
    .which_core_drained(drained), .out_row_mem_sel(sel),
    .out_row_mem_en(en), .out_row_mem_addr(raddr), .out_row_mem_data(rdata),
    .out_mem_data(wdata), .out_mem_addr(waddr), .out_mem_we(we)
  );

  function automatic logic [7:0] data_of(input int seed, input int j);
    return 8'(seed + j);
  endfunction

  task automatic load_row(input int c, input int tl);
    tags[c*6 +: 6] = 6'(q_tag[c][0]);
    for (int j = 0; j < tl && j < MEMD; j++) mem[c][j] = data_of(q_seed[c][0], j);
    valid[c] = 1'b1;
  endtask

  task automatic clear_cores();
    valid = '0;
    for (int c = 0; c < NC; c++) begin
      q_tag[c].delete();
      q_seed[c].delete();
      pend[c] = 0;
    end
  endtask

  // Runs one layer with the rows queued in q_tag/q_seed. Cores in 'late'
  // raise their first row only once the first row of the layer is released.
  task automatic run_layer(input string name, input int h, input int w, input int o,
                           input logic [NC-1:0] late);
    int tl, p, f, budget, low, cyc, c;
    int idx [NC];
    int ea[$], oa[$], edr[$], odr[$];
    logic [7:0] ed[$], od[$];
    bit finished, injected, late_loaded;
    tl = w * o; p = 0; low = 0;
    finished = 0; injected = 0; late_loaded = 0;
    for (int k = 0; k < NC; k++) idx[k] = 0;
    // Reference: each row goes to the next core (cyclically from the pointer)
    // that still has a row available; the pointer then moves past that core.
    for (int r = 0; r < h; r++) begin
      f = -1;
      for (int k = 0; k < NC; k++) begin
        c = (p + k) % NC;
        if (f < 0 && idx[c] < q_tag[c].size() && !(r == 0 && late[c])) f = c;
      end
      if (f >= 0) begin
        for (int j = 0; j < tl; j++) begin
          ea.push_back(q_tag[f][idx[f]] * tl + j);
          ed.push_back(data_of(q_seed[f][idx[f]], j));
        end
        edr.push_back(f);
        idx[f]++;
        p = (f + 1) % NC;
      end
    end
    budget = h * (tl + 2) + 40;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      pend[k] = 0;
      if (!late[k] && q_tag[k].size() > 0) load_row(k, tl);
    end
    img_h = 6'(h); img_w = 6'(w); oc = 8'(o); start = 1'b1;
    for (cyc = 0; cyc < budget && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (we) begin oa.push_back(int'(waddr)); od.push_back(wdata); end
      for (int k = 0; k < NC; k++) begin
        if (pend[k]) begin
          pend[k] = 0;
          if (q_tag[k].size() > 0) load_row(k, tl);
        end
      end
      if (drained != '0) begin
        checks++;
        if (!$onehot(drained)) $display("FAIL %s drained_onehot: got %b", name, drained);
        else passed++;
        checks++;
        if (we !== 1'(tl > 0)) $display("FAIL %s last_write_with_drain: we=%b required %b", name, we, tl > 0);
        else passed++;
        for (int k = 0; k < NC; k++) begin
          if (drained[k]) begin
            odr.push_back(k);
            valid[k] = 1'b0;
            if (q_tag[k].size() > 0) begin
              void'(q_tag[k].pop_front());
              void'(q_seed[k].pop_front());
            end
            pend[k] = 1;
          end
        end
        if (!late_loaded) begin
          late_loaded = 1;
          for (int k = 0; k < NC; k++) if (late[k] && q_tag[k].size() > 0) load_row(k, tl);
        end
      end
      if (done !== 1'b1) begin
        low++;
        if (low == 2 && !injected) begin
          // start and new geometry while busy must have no effect
          injected = 1; start = 1'b1;
          img_h = 6'($urandom); img_w = 6'($urandom); oc = 8'($urandom);
        end
      end else if (low > 0 || h == 0) begin
        finished = 1;
      end
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (we) begin oa.push_back(int'(waddr)); od.push_back(wdata); end
      for (int k = 0; k < NC; k++) if (drained[k]) odr.push_back(k);
    end
    clear_cores();
    checks++;
    if (!finished) $display("FAIL %s timeout: done not reached within %0d cycles", name, budget);
    else passed++;
    checks++;
    if (low != h * (tl + 2)) $display("FAIL %s busy_cycles: got %0d required %0d", name, low, h * (tl + 2));
    else passed++;
    checks++;
    if (oa.size() != ea.size()) $display("FAIL %s write_count: got %0d required %0d", name, oa.size(), ea.size());
    else passed++;
    for (int i = 0; i < oa.size() && i < ea.size(); i++) begin
      checks++;
      if (oa[i] !== ea[i] || od[i] !== ed[i])
        $display("FAIL %s write[%0d]: got addr %0d data %0d required addr %0d data %0d",
                 name, i, oa[i], od[i], ea[i], ed[i]);
      else passed++;
    end
    checks++;
    if (odr.size() != edr.size()) $display("FAIL %s drain_count: got %0d required %0d", name, odr.size(), edr.size());
    else passed++;
    for (int i = 0; i < odr.size() && i < edr.size(); i++) begin
      checks++;
      if (odr[i] !== edr[i]) $display("FAIL %s drain[%0d]: got core %0d required core %0d", name, i, odr[i], edr[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; valid = '0; tags = '0;
    img_h = '0; img_w = '0; oc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL reset_done: got %b required 1", done);
    else passed++;
    checks++;
    if ({en, we, drained, sel, raddr, waddr, wdata} !== '0)
      $display("FAIL reset_outputs: en=%b we=%b drained=%b sel=%0d raddr=%0d waddr=%0d wdata=%0d required all 0",
               en, we, drained, sel, raddr, waddr, wdata);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single_core();
    q_tag[0].push_back(0); q_seed[0].push_back(1);
    run_layer("single_core", 1, 2, 3, '0);
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < NC; c++) begin
      q_tag[c].push_back(3 - c); q_seed[c].push_back(16 * c + 5);
    end
    run_layer("round_robin", 4, 1, 4, '0);
  endtask

  task automatic test_fairness();
    q_tag[1].push_back(7); q_seed[1].push_back(100);
    q_tag[0].push_back(1); q_seed[0].push_back(50);
    q_tag[3].push_back(2); q_seed[3].push_back(200);
    run_layer("fairness", 3, 2, 3, 4'b1001);
  endtask

  task automatic test_wait_state();
    int nw;
    bit got_done;
    nw = 0; got_done = 0;
    @(negedge clk);
    valid = '0; img_h = 6'd1; img_w = 6'd2; oc = 8'd2; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({en, we, done} !== 3'b000) $display("FAIL wait_idle[%0d]: en=%b we=%b done=%b required 000", i, en, we, done);
      else passed++;
    end
    for (int j = 0; j < 4; j++) mem[1][j] = 8'(40 + j);
    tags[6 +: 6] = 6'd5;
    valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || sel !== 2'd1 || raddr !== 14'd0)
      $display("FAIL wait_first_read: en=%b sel=%0d addr=%0d required en=1 sel=1 addr=0", en, sel, raddr);
    else passed++;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (we) begin
        checks++;
        if (waddr !== 20'(20 + nw) || wdata !== 8'(40 + nw))
          $display("FAIL wait_write[%0d]: got addr %0d data %0d required addr %0d data %0d",
                   nw, waddr, wdata, 20 + nw, 40 + nw);
        else passed++;
        nw++;
      end
      if (drained[1]) valid[1] = 1'b0;
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done || nw != 4) $display("FAIL wait_completion: done_seen=%0d writes=%0d required 1 and 4", got_done, nw);
    else passed++;
    clear_cores();
  endtask

  task automatic test_degenerate();
    q_tag[0].push_back(9); q_seed[0].push_back(3);
    run_layer("zero_rows", 0, 3, 3, '0);
    q_tag[2].push_back(4); q_seed[2].push_back(8);
    run_layer("zero_oc", 1, 3, 0, '0);
  endtask

  task automatic test_random();
    int h, w, o, c;
    for (int it = 0; it < 6; it++) begin
      h = $urandom_range(1, 8);
      w = $urandom_range(1, 5);
      o = $urandom_range(0, 5);
      for (int r = 0; r < h; r++) begin
        c = $urandom_range(0, NC - 1);
        q_tag[c].push_back($urandom_range(0, 63));
        q_seed[c].push_back(int'($urandom_range(0, 255)));
      end
      run_layer($sformatf("random%0d", it), h, w, o, '0);
    end
  endtask

  task automatic test_mid_row_reset();
    bit hit;
    hit = 0;
    q_tag[0].push_back(2); q_seed[0].push_back(9);
    @(negedge clk);
    load_row(0, 16);
    img_h = 6'd1; img_w = 6'd4; oc = 8'd4; start = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (en === 1'b1 && raddr === 14'd5) hit = 1;
    end
    checks++;
    if (!hit) $display("FAIL mid_reset_reach: read address 5 not reached");
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({en, we, drained} !== '0 || done !== 1'b1)
      $display("FAIL mid_reset_outputs: en=%b we=%b drained=%b done=%b required 0 0 0000 1", en, we, drained, done);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({en, we, drained} !== '0 || done !== 1'b1)
        $display("FAIL mid_reset_idle[%0d]: en=%b we=%b drained=%b done=%b required idle", i, en, we, drained, done);
      else passed++;
    end
    clear_cores();
  endtask

  initial begin
    clear_cores();
    test_reset();
    test_single_core();
    test_round_robin();
    test_fairness();
    test_wait_state();
    test_degenerate();
    test_random();
    test_mid_row_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
